// File: rtl/load_store_unit_if.sv
// Bundles the core-side request/response signals and the data-memory req/ack bus
// of the load/store unit. The unit uses the slave view; the core and memory use the master view.
interface load_store_unit_if #(
  parameter int BUS_WIDTH = 32
);
  // Core side
  logic                 start;
  logic                 isStore;
  logic [2:0]           funct3;
  logic [BUS_WIDTH-1:0] addr;
  logic [BUS_WIDTH-1:0] wrData;
  logic                 ready;
  logic                 done;
  logic [BUS_WIDTH-1:0] rdData;
  logic                 fault;
  logic [1:0]           faultCode;
  // Memory side
  logic                 memReq;
  logic                 memWe;
  logic [BUS_WIDTH-1:0] memAddr;
  logic [3:0]           memByteEna;
  logic [BUS_WIDTH-1:0] memWrData;
  logic                 memAck;
  logic [BUS_WIDTH-1:0] memRdData;

  modport slave (
    input  start, isStore, funct3, addr, wrData, memAck, memRdData,
    output ready, done, rdData, fault, faultCode,
           memReq, memWe, memAddr, memByteEna, memWrData
  );

  modport master (
    output start, isStore, funct3, addr, wrData, memAck, memRdData,
    input  ready, done, rdData, fault, faultCode,
           memReq, memWe, memAddr, memByteEna, memWrData
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one data-memory transaction per request over a req/ack bus,
// with lane steering, load extension and misalign/illegal/timeout fault reporting.
module load_store_unit #(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILLEGAL  = 2'b11;
  localparam logic [7:0] LAST_CYCLE  = 8'(TIMEOUT_CYCLES - 1);

  state_t               r_state, w_state_next;
  logic [2:0]           r_funct3, w_funct3_next;
  logic [1:0]           r_addr_lo, w_addr_lo_next;
  logic                 r_is_store, w_is_store_next;
  logic [7:0]           r_cnt, w_cnt_next;

  logic                 r_ready, w_ready;
  logic                 r_done, w_done;
  logic                 r_fault, w_fault;
  logic [1:0]           r_fault_code, w_fault_code;
  logic [BUS_WIDTH-1:0] r_rd_data, w_rd_data;
  logic                 r_mem_req, w_mem_req;
  logic                 r_mem_we, w_mem_we;
  logic [BUS_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [3:0]           r_mem_bena, w_mem_bena;
  logic [BUS_WIDTH-1:0] r_mem_wdata, w_mem_wdata;

  logic                 w_illegal, w_misaligned;
  logic [3:0]           w_bena;
  logic [BUS_WIDTH-1:0] w_wdata, w_shifted, w_load_data;

  // Request decode straight from the core inputs, used on the accepting edge.
  // NOTE: every combinational output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_illegal    = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11) ||
                   (bus.funct3[2] && bus.isStore);
    w_misaligned = 1'b0;
    w_bena       = 4'b1111;
    w_wdata      = bus.wrData;
    case (bus.funct3[1:0])
      2'b00: begin
        w_bena  = 4'b0001 << bus.addr[1:0];
        w_wdata = {4{bus.wrData[7:0]}};
      end
      2'b01: begin
        w_misaligned = bus.addr[0];
        w_bena       = 4'b0011 << {bus.addr[1], 1'b0};
        w_wdata      = {2{bus.wrData[15:0]}};
      end
      default: begin
        w_misaligned = |bus.addr[1:0];
      end
    endcase
  end

  // Load lane extraction: shift the addressed byte/half down to bit 0, then extend.
  assign w_shifted = bus.memRdData >> {r_addr_lo, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_funct3)
      3'b000:  w_load_data = {{(BUS_WIDTH-8){w_shifted[7]}},   w_shifted[7:0]};
      3'b001:  w_load_data = {{(BUS_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {{(BUS_WIDTH-8){1'b0}},           w_shifted[7:0]};
      3'b101:  w_load_data = {{(BUS_WIDTH-16){1'b0}},          w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_state_next    = r_state;
    w_funct3_next   = r_funct3;
    w_addr_lo_next  = r_addr_lo;
    w_is_store_next = r_is_store;
    w_cnt_next      = r_cnt;
    w_done          = 1'b0;
    w_fault         = 1'b0;
    w_fault_code    = r_fault_code;
    w_rd_data       = r_rd_data;
    w_mem_req       = 1'b0;
    w_mem_we        = 1'b0;
    w_mem_addr      = r_mem_addr;
    w_mem_bena      = r_mem_bena;
    w_mem_wdata     = r_mem_wdata;

    case (r_state)
      S_IDLE: begin
        if (bus.start && r_ready) begin
          w_funct3_next   = bus.funct3;
          w_addr_lo_next  = bus.addr[1:0];
          w_is_store_next = bus.isStore;
          if (w_illegal || w_misaligned) begin
            w_state_next = S_RESP;
            w_done       = 1'b1;
            w_fault      = 1'b1;
            w_fault_code = w_illegal ? FC_ILLEGAL : FC_MISALIGN;
            w_rd_data    = '0;
          end else begin
            w_state_next = S_ACCESS;
            w_cnt_next   = '0;
            w_mem_req    = 1'b1;
            w_mem_we     = bus.isStore;
            w_mem_addr   = {bus.addr[BUS_WIDTH-1:2], 2'b00};
            w_mem_bena   = w_bena;
            w_mem_wdata  = w_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (bus.memAck) begin
          w_state_next = S_RESP;
          w_done       = 1'b1;
          w_fault_code = FC_NONE;
          w_rd_data    = r_is_store ? '0 : w_load_data;
        end else if (r_cnt == LAST_CYCLE) begin
          w_state_next = S_RESP;
          w_done       = 1'b1;
          w_fault      = 1'b1;
          w_fault_code = FC_TIMEOUT;
          w_rd_data    = '0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
          w_mem_req  = 1'b1;
          w_mem_we   = r_mem_we;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    w_ready = (w_state_next == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_funct3     <= '0;
      r_addr_lo    <= '0;
      r_is_store   <= 1'b0;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= '0;
      r_rd_data    <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_bena   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_funct3     <= w_funct3_next;
      r_addr_lo    <= w_addr_lo_next;
      r_is_store   <= w_is_store_next;
      r_cnt        <= w_cnt_next;
      r_ready      <= w_ready;
      r_done       <= w_done;
      r_fault      <= w_fault;
      r_fault_code <= w_fault_code;
      r_rd_data    <= w_rd_data;
      r_mem_req    <= w_mem_req;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_bena   <= w_mem_bena;
      r_mem_wdata  <= w_mem_wdata;
    end
  end

  assign bus.ready      = r_ready;
  assign bus.done       = r_done;
  assign bus.rdData     = r_rd_data;
  assign bus.fault      = r_fault;
  assign bus.faultCode  = r_fault_code;
  assign bus.memReq     = r_mem_req;
  assign bus.memWe      = r_mem_we;
  assign bus.memAddr    = r_mem_addr;
  assign bus.memByteEna = r_mem_bena;
  assign bus.memWrData  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle corner
// sequences (late ack, mid-access reset, start while busy) and randomized ops vs. a reference model.
module tb_load_store_unit;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.BUS_WIDTH(32)) bus ();

  load_store_unit #(.BUS_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ack_after;  // req cycle in which memory acks; 0 = never
  } op_t;

  typedef struct {
    int          done_cyc;   // cycles after the accepting edge; 0 = cycle right after it
    int          req;
    logic [3:0]  bena;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rddata;
    logic        we;
    logic        fault;
    logic [1:0]  code;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t ex;
  } vec_t;

  typedef struct {
    int          done_cyc;
    int          req;
    logic [3:0]  bena;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rddata;
    logic        we;
    logic        fault;
    logic [1:0]  code;
    logic        stable;
    logic        ready_after;
    logic        done_after;
  } res_t;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, id, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int ack,
                              input int dc, input int rq, input logic [3:0] be,
                              input logic [31:0] ma, input logic [31:0] mw, input logic [31:0] rdx,
                              input logic flt, input logic [1:0] code);
    vec_t v;
    v.op.st = st; v.op.f3 = f3; v.op.addr = a; v.op.wd = wd; v.op.rd = rd; v.op.ack_after = ack;
    v.ex.done_cyc = dc; v.ex.req = rq; v.ex.bena = be; v.ex.maddr = ma; v.ex.mwdata = mw;
    v.ex.rddata = rdx; v.ex.we = st; v.ex.fault = flt; v.ex.code = code;
    return v;
  endfunction

  // Reference model: size/offset arithmetic on the RISC-V access rules.
  function automatic exp_t model(input op_t op);
    exp_t        e;
    int          size;
    int          off;
    logic [31:0] mask;
    logic [31:0] v;
    e.done_cyc = 0; e.req = 0; e.bena = '0; e.maddr = '0; e.mwdata = '0;
    e.rddata = '0; e.we = op.st; e.fault = 1'b0; e.code = 2'b00;
    size = 1 << op.f3[1:0];
    off  = int'(op.addr % 32'd4);
    if (op.f3 == 3'd3 || op.f3 >= 3'd6 || (op.st && op.f3 >= 3'd4)) begin
      e.fault = 1'b1; e.code = 2'b11;
      return e;
    end
    if (off % size != 0) begin
      e.fault = 1'b1; e.code = 2'b01;
      return e;
    end
    e.maddr = op.addr - 32'(off);
    for (int i = 0; i < 4; i++) begin
      e.bena[i] = (i >= off) && (i < off + size);
      e.mwdata[8*i +: 8] = op.wd[8*(i % size) +: 8];
    end
    if (op.ack_after == 0) begin
      e.req = TO; e.done_cyc = TO; e.fault = 1'b1; e.code = 2'b10;
      return e;
    end
    e.req = op.ack_after; e.done_cyc = op.ack_after;
    if (!op.st) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
      v = (op.rd >> (8*off)) & mask;
      if (op.f3 < 3'd4 && v[8*size-1]) v = v | ~mask;
      e.rddata = v;
    end
    return e;
  endfunction

  // Issue one request and act as the memory; samples on the falling edge.
  task automatic run_op(input op_t op, output res_t r);
    bit done_seen;
    int cyc;
    r.done_cyc = -1; r.req = 0; r.bena = '0; r.maddr = '0; r.mwdata = '0; r.rddata = '0;
    r.we = 1'b0; r.fault = 1'b0; r.code = 2'b00; r.stable = 1'b1;
    r.ready_after = 1'b0; r.done_after = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.isStore = op.st; bus.funct3 = op.f3;
    bus.addr = op.addr; bus.wrData = op.wd;
    @(negedge clk);
    bus.start = 1'b0;
    done_seen = 1'b0;
    cyc = 0;
    while (!done_seen && cyc < 40) begin
      if (bus.memReq) begin
        if (r.req == 0) begin
          r.we = bus.memWe; r.maddr = bus.memAddr; r.bena = bus.memByteEna; r.mwdata = bus.memWrData;
        end else if (r.we !== bus.memWe || r.maddr !== bus.memAddr ||
                     r.bena !== bus.memByteEna || r.mwdata !== bus.memWrData) begin
          r.stable = 1'b0;
        end
        r.req++;
        if (r.req == op.ack_after) begin
          bus.memAck = 1'b1; bus.memRdData = op.rd;
        end
      end
      if (bus.done) begin
        done_seen = 1'b1; r.done_cyc = cyc;
        r.rddata = bus.rdData; r.fault = bus.fault; r.code = bus.faultCode;
      end
      @(negedge clk);
      bus.memAck = 1'b0; bus.memRdData = $urandom;
      cyc++;
    end
    r.ready_after = bus.ready;
    r.done_after  = bus.done;
  endtask

  task automatic compare(input int id, input res_t r, input exp_t e);
    check("done_cycle", id, 32'(r.done_cyc), 32'(e.done_cyc));
    check("req_cycles", id, 32'(r.req), 32'(e.req));
    check("fault", id, 32'(r.fault), 32'(e.fault));
    check("fault_code", id, 32'(r.code), 32'(e.code));
    check("ready_after_done", id, 32'(r.ready_after), 32'd1);
    check("done_single_pulse", id, 32'(r.done_after), 32'd0);
    if (e.req > 0) begin
      check("rd_data", id, r.rddata, e.rddata);
      check("mem_we", id, 32'(r.we), 32'(e.we));
      check("mem_addr", id, r.maddr, e.maddr);
      check("byte_ena", id, 32'(r.bena), 32'(e.bena));
      check("req_fields_stable", id, 32'(r.stable), 32'd1);
      if (e.we) check("mem_wr_data", id, r.mwdata, e.mwdata);
    end
  endtask

  vec_t tbl[$];
  logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    res_t r;
    op_t  op;
    int   cnt;
    int   req_cnt;
    logic [31:0] rd_cap;

    bus.start = 1'b0; bus.isStore = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wrData = '0;
    bus.memAck = 1'b0; bus.memRdData = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 0, 32'(bus.ready), 32'd0);
    check("reset_outputs", 0, 32'({bus.done, bus.fault, bus.memReq, bus.memWe, bus.faultCode, bus.memByteEna}), 32'd0);
    check("reset_rd_data", 0, bus.rdData, 32'd0);
    check("reset_mem_addr", 0, bus.memAddr, 32'd0);
    check("reset_mem_wr_data", 0, bus.memWrData, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 0, 32'(bus.ready), 32'd1);

    //          st  f3     addr          wd            rd            ack dc  rq  bena     maddr         mwdata        rddata        flt  code
    tbl.push_back(mk(0, 3'b000, 32'h0000_0103, 32'h0,         32'h8000_0000, 3,  3,  3,  4'b1000, 32'h100, 32'h0,         32'hFFFF_FF80, 0, 2'b00));
    tbl.push_back(mk(0, 3'b101, 32'h0000_0202, 32'h0,         32'hBEEF_1234, 2,  2,  2,  4'b1100, 32'h200, 32'h0,         32'h0000_BEEF, 0, 2'b00));
    tbl.push_back(mk(0, 3'b010, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 1,  1,  1,  4'b1111, 32'h008, 32'h0,         32'hCAFE_F00D, 0, 2'b00));
    tbl.push_back(mk(1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h0,         1,  1,  1,  4'b0010, 32'h010, 32'hA5A5_A5A5, 32'h0,         0, 2'b00));
    tbl.push_back(mk(1, 3'b001, 32'h0000_0012, 32'h0000_1234, 32'h0,         2,  2,  2,  4'b1100, 32'h010, 32'h1234_1234, 32'h0,         0, 2'b00));
    tbl.push_back(mk(1, 3'b010, 32'h0000_0024, 32'hDEAD_BEEF, 32'h0,         1,  1,  1,  4'b1111, 32'h024, 32'hDEAD_BEEF, 32'h0,         0, 2'b00));
    tbl.push_back(mk(0, 3'b001, 32'h0000_0302, 32'h0,         32'h8001_0000, 1,  1,  1,  4'b1100, 32'h300, 32'h0,         32'hFFFF_8001, 0, 2'b00));
    tbl.push_back(mk(0, 3'b100, 32'h0000_0001, 32'h0,         32'h0000_F000, 2,  2,  2,  4'b0010, 32'h000, 32'h0,         32'h0000_00F0, 0, 2'b00));
    tbl.push_back(mk(0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,         1,  0,  0,  4'b0000, 32'h0,   32'h0,         32'h0,         1, 2'b01));
    tbl.push_back(mk(0, 3'b101, 32'h0000_0003, 32'h0,         32'h0,         1,  0,  0,  4'b0000, 32'h0,   32'h0,         32'h0,         1, 2'b01));
    tbl.push_back(mk(1, 3'b100, 32'h0000_0020, 32'h0,         32'h0,         1,  0,  0,  4'b0000, 32'h0,   32'h0,         32'h0,         1, 2'b11));
    tbl.push_back(mk(0, 3'b111, 32'h0000_0001, 32'h0,         32'h0,         1,  0,  0,  4'b0000, 32'h0,   32'h0,         32'h0,         1, 2'b11));
    tbl.push_back(mk(0, 3'b010, 32'h0000_0044, 32'h0,         32'h1357_2468, 16, 16, 16, 4'b1111, 32'h044, 32'h0,         32'h1357_2468, 0, 2'b00));
    tbl.push_back(mk(0, 3'b010, 32'h0000_0040, 32'h0,         32'h1111_1111, 0,  16, 16, 4'b1111, 32'h040, 32'h0,         32'h0,         1, 2'b10));

    foreach (tbl[i]) begin
      run_op(tbl[i].op, r);
      compare(i, r, tbl[i].ex);
    end

    // Late ack two cycles after a timeout must not produce a response.
    @(negedge clk);
    bus.memAck = 1'b1; bus.memRdData = 32'h7777_7777;
    @(negedge clk);
    bus.memAck = 1'b0;
    cnt = 0;
    repeat (3) begin
      if (bus.done || bus.memReq) cnt++;
      @(negedge clk);
    end
    check("late_ack_ignored", 100, 32'(cnt), 32'd0);
    check("late_ack_ready", 100, 32'(bus.ready), 32'd1);

    // Reset in the middle of an access, then an ack that must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.isStore = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h80;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_req_before_reset", 101, 32'(bus.memReq), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_req_dropped", 101, 32'(bus.memReq), 32'd0);
    check("abort_ready_in_reset", 101, 32'(bus.ready), 32'd0);
    bus.memAck = 1'b1; bus.memRdData = 32'h1234_5678;
    @(negedge clk);
    bus.memAck = 1'b0;
    check("abort_ready_after", 101, 32'(bus.ready), 32'd1);
    cnt = 0;
    repeat (4) begin
      if (bus.done || bus.memReq) cnt++;
      @(negedge clk);
    end
    check("abort_no_done", 101, 32'(cnt), 32'd0);

    // start pulsed while busy is dropped: one transaction, one done.
    @(negedge clk);
    bus.start = 1'b1; bus.isStore = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h84;
    @(negedge clk);
    cnt = 0; req_cnt = 0; rd_cap = '0;
    for (int c = 0; c < 12; c++) begin
      bus.start = (c == 1 || c == 2);
      bus.addr  = 32'h88;
      if (bus.memReq) begin
        req_cnt++;
        if (req_cnt == 3) begin
          bus.memAck = 1'b1; bus.memRdData = 32'h5A5A_0000;
        end
      end
      if (bus.done) begin
        cnt++; rd_cap = bus.rdData;
      end
      @(negedge clk);
      bus.memAck = 1'b0;
    end
    bus.start = 1'b0;
    check("busy_done_count", 102, 32'(cnt), 32'd1);
    check("busy_req_cycles", 102, 32'(req_cnt), 32'd3);
    check("busy_rd_data", 102, rd_cap, 32'h5A5A_0000);

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 11));
      op.st = 1'($urandom_range(0, 1));
      if (sel < 10)       op.f3 = legal_f3[sel % 5];
      else if (sel == 10) op.f3 = 3'b011;
      else                op.f3 = {2'b11, 1'($urandom_range(0, 1))};
      op.addr = $urandom;
      op.wd   = $urandom;
      op.rd   = $urandom;
      op.ack_after = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 5));
      run_op(op, r);
      compare(200 + i, r, model(op));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
